// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage instruction queue.
// ld_op bit positions follow the {ld_b, ld_bu, ld_h, ld_hu, ld_w} bundle from EX.
package mem_pkg;

   localparam int LD_OP_W   = 5;
   localparam int LD_W_BIT  = 0;
   localparam int LD_HU_BIT = 1;
   localparam int LD_H_BIT  = 2;
   localparam int LD_BU_BIT = 3;
   localparam int LD_B_BIT  = 4;

   localparam int MEM_EXC_W = 85;

   // The exception bundle is kept beside this record because its width is a
   // per-instance parameter.
   typedef struct packed {
      logic                valid;
      logic                waiting;
      logic                got;
      logic [31:0]         data;
      logic [LD_OP_W-1:0]  ld_op;
      logic [1:0]          addr_lo;
      logic                rf_we;
      logic [4:0]          waddr;
      logic [31:0]         result;
      logic [31:0]         pc;
   } mem_entry_t;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: shifts the SRAM word down by the byte offset and extends
// according to the load type.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0]        rdata,
   input  logic [1:0]         addr_lo,
   input  logic [LD_OP_W-1:0] ld_op,
   output logic [31:0]        result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {addr_lo, 3'b000};
      if (ld_op[LD_B_BIT])
         result = {{24{shifted[7]}}, shifted[7:0]};
      else if (ld_op[LD_BU_BIT])
         result = {24'b0, shifted[7:0]};
      else if (ld_op[LD_H_BIT])
         result = {{16{shifted[15]}}, shifted[15:0]};
      else if (ld_op[LD_HU_BIT])
         result = {16'b0, shifted[15:0]};
      else
         result = shifted;
   end

endmodule

// File: rtl/mem_stage_queue.sv
// MEM stage: in-order queue of up to DEPTH instructions between EX and WB,
// matching in-order SRAM responses to the oldest waiting entry.
module mem_stage_queue
   import mem_pkg::*;
#(
   parameter  int DEPTH = 2,
   parameter  int EXC_W = MEM_EXC_W,
   localparam int CNT_W = cnt_w(DEPTH)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               es2ms_valid,
   output logic               ms_allowin,
   input  logic               es_mem_op,
   input  logic [LD_OP_W-1:0] es_ld_op,
   input  logic [1:0]         es_addr_lo,
   input  logic               es_rf_we,
   input  logic [4:0]         es_rf_waddr,
   input  logic [31:0]        es_result,
   input  logic [31:0]        es_pc,
   input  logic [EXC_W-1:0]   es_ex_code,
   input  logic               es_req_fire,
   output logic               ms_req_stall,
   input  logic               data_sram_data_ok,
   input  logic [31:0]        data_sram_rdata,
   input  logic               ws_allowin,
   output logic               ms2ws_valid,
   output logic [31:0]        ms_pc,
   output logic               ms_rf_we,
   output logic [4:0]         ms_rf_waddr,
   output logic [31:0]        ms_rf_wdata,
   output logic [EXC_W-1:0]   ms_ex_code,
   output logic               ms_ex,
   input  logic               wb_ex,
   output logic [31:0]        ms_wr_mask,
   output logic               ms_fwd_valid,
   output logic [4:0]         ms_fwd_waddr,
   output logic [31:0]        ms_fwd_wdata,
   output logic [CNT_W-1:0]   ms_outstanding
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W:0]   OUT_MAX  = (CNT_W + 1)'(DEPTH);

   mem_entry_t       ent   [DEPTH];
   mem_entry_t       ent_n [DEPTH];
   logic [EXC_W-1:0] exc   [DEPTH];
   logic [EXC_W-1:0] exc_n [DEPTH];

   logic [PTR_W-1:0] head, tail, resp;
   logic [PTR_W-1:0] head_n, tail_n, resp_n;
   logic [CNT_W-1:0] outstanding, outstanding_n;
   // One bit wider than the counter: a flush may need to swallow a request
   // fired in the same cycle on top of a full set of outstanding ones.
   logic [CNT_W:0]   discard, discard_n;
   logic [CNT_W:0]   out_sum;

   logic        resp_hit, ok_eff, bypass, head_done, retire, enq;
   logic [31:0] align_out;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= DEPTH) s = s - DEPTH;
      return PTR_W'(s);
   endfunction

   assign resp_hit  = data_sram_data_ok & (discard == '0) & ent[resp].valid
                    & ent[resp].waiting & ~ent[resp].got;
   assign ok_eff    = data_sram_data_ok & ((discard != '0) | resp_hit);
   assign bypass    = resp_hit & (resp == head);
   assign head_done = ent[head].valid & (~ent[head].waiting | ent[head].got | bypass);
   assign retire    = head_done & ws_allowin;
   assign enq       = es2ms_valid & ms_allowin & ~wb_ex;

   assign ms_allowin     = ~ent[tail].valid | retire;
   assign ms_req_stall   = (outstanding == CNT_W'(DEPTH));
   assign ms_outstanding = outstanding;

   // The aligner always looks at the entry the next response belongs to; the
   // captured value is stored already aligned so forwarding needs no second copy.
   mem_load_align u_align (
      .rdata   (data_sram_rdata),
      .addr_lo (ent[resp].addr_lo),
      .ld_op   (ent[resp].ld_op),
      .result  (align_out)
   );

   assign ms2ws_valid = head_done;
   assign ms_pc       = ent[head].pc;
   assign ms_rf_we    = ent[head].rf_we;
   assign ms_rf_waddr = ent[head].waddr;
   assign ms_ex_code  = exc[head];
   assign ms_rf_wdata = ~|ent[head].ld_op ? ent[head].result :
                        ent[head].got     ? ent[head].data   :
                        bypass            ? align_out        : '0;

   always_comb begin
      ms_ex        = 1'b0;
      ms_wr_mask   = '0;
      ms_fwd_valid = 1'b0;
      ms_fwd_waddr = '0;
      ms_fwd_wdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent[i].valid && |exc[i]) ms_ex = 1'b1;
         if (ent[i].valid && ent[i].rf_we) ms_wr_mask[ent[i].waddr] = 1'b1;
      end
      // Walk oldest to youngest so the youngest writer decides the result.
      for (int k = 0; k < DEPTH; k++) begin
         if (ent[ptr_add(head, k)].valid && ent[ptr_add(head, k)].rf_we) begin
            if (~ent[ptr_add(head, k)].waiting | ent[ptr_add(head, k)].got) begin
               ms_fwd_valid = 1'b1;
               ms_fwd_waddr = ent[ptr_add(head, k)].waddr;
               ms_fwd_wdata = |ent[ptr_add(head, k)].ld_op ? ent[ptr_add(head, k)].data
                                                           : ent[ptr_add(head, k)].result;
            end else begin
               ms_fwd_valid = 1'b0;
               ms_fwd_waddr = '0;
               ms_fwd_wdata = '0;
            end
         end
      end
   end

   always_comb begin
      ent_n  = ent;
      exc_n  = exc;
      head_n = head;
      tail_n = tail;
      if (wb_ex) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_n[i] = '0;
            exc_n[i] = '0;
         end
         head_n = '0;
         tail_n = '0;
      end else begin
         if (resp_hit) begin
            ent_n[resp].data = align_out;
            ent_n[resp].got  = 1'b1;
         end
         if (retire) begin
            ent_n[head] = '0;
            exc_n[head] = '0;
            head_n      = ptr_inc(head);
         end
         // When full, tail equals head, so this lands in the slot just retired.
         if (enq) begin
            ent_n[tail].valid   = 1'b1;
            ent_n[tail].waiting = es_mem_op & ~|es_ex_code;
            ent_n[tail].got     = 1'b0;
            ent_n[tail].data    = '0;
            ent_n[tail].ld_op   = es_ld_op;
            ent_n[tail].addr_lo = es_addr_lo;
            ent_n[tail].rf_we   = es_rf_we;
            ent_n[tail].waddr   = es_rf_waddr;
            ent_n[tail].result  = es_result;
            ent_n[tail].pc      = es_pc;
            exc_n[tail]         = es_ex_code;
            tail_n              = ptr_inc(tail);
         end
      end
      resp_n = tail_n;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (ent_n[ptr_add(head_n, k)].valid && ent_n[ptr_add(head_n, k)].waiting
             && !ent_n[ptr_add(head_n, k)].got)
            resp_n = ptr_add(head_n, k);
      end
   end

   always_comb begin
      out_sum = {1'b0, outstanding} + (CNT_W + 1)'(es_req_fire);
      if (ok_eff && out_sum != '0) out_sum = out_sum - 1'b1;
      outstanding_n = (out_sum > OUT_MAX) ? CNT_W'(DEPTH) : out_sum[CNT_W-1:0];
      discard_n     = discard;
      if (wb_ex)
         discard_n = out_sum;
      else if (data_sram_data_ok && discard != '0)
         discard_n = discard - 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent[i] <= '0;
            exc[i] <= '0;
         end
         head        <= '0;
         tail        <= '0;
         resp        <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         ent         <= ent_n;
         exc         <= exc_n;
         head        <= head_n;
         tail        <= tail_n;
         resp        <= resp_n;
         outstanding <= outstanding_n;
         discard     <= discard_n;
      end
   end

   a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
      (data_sram_data_ok && discard == '0) |-> resp_hit);

endmodule

// File: tb/tb_mem_stage_queue.sv
// Self-checking bench for mem_stage_queue (DEPTH=2): a scoreboard of expected
// retirements plus per-scenario inline checks.
module tb_mem_stage_queue;

   localparam int DEPTH = 2;
   localparam int EXC_W = 85;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk, resetn;
   logic             es2ms_valid, ms_allowin, es_mem_op;
   logic [4:0]       es_ld_op;
   logic [1:0]       es_addr_lo;
   logic             es_rf_we;
   logic [4:0]       es_rf_waddr;
   logic [31:0]      es_result, es_pc;
   logic [EXC_W-1:0] es_ex_code;
   logic             es_req_fire, ms_req_stall;
   logic             data_sram_data_ok;
   logic [31:0]      data_sram_rdata;
   logic             ws_allowin, ms2ws_valid;
   logic [31:0]      ms_pc;
   logic             ms_rf_we;
   logic [4:0]       ms_rf_waddr;
   logic [31:0]      ms_rf_wdata;
   logic [EXC_W-1:0] ms_ex_code;
   logic             ms_ex, wb_ex;
   logic [31:0]      ms_wr_mask;
   logic             ms_fwd_valid;
   logic [4:0]       ms_fwd_waddr;
   logic [31:0]      ms_fwd_wdata;
   logic [CNT_W-1:0] ms_outstanding;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   mem_stage_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
      .clk(clk), .resetn(resetn),
      .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin),
      .es_mem_op(es_mem_op), .es_ld_op(es_ld_op), .es_addr_lo(es_addr_lo),
      .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_result(es_result),
      .es_pc(es_pc), .es_ex_code(es_ex_code),
      .es_req_fire(es_req_fire), .ms_req_stall(ms_req_stall),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .ws_allowin(ws_allowin), .ms2ws_valid(ms2ws_valid),
      .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
      .ms_rf_wdata(ms_rf_wdata), .ms_ex_code(ms_ex_code), .ms_ex(ms_ex),
      .wb_ex(wb_ex), .ms_wr_mask(ms_wr_mask),
      .ms_fwd_valid(ms_fwd_valid), .ms_fwd_waddr(ms_fwd_waddr),
      .ms_fwd_wdata(ms_fwd_wdata), .ms_outstanding(ms_outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard consumer: every retirement must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (resetn && ms2ws_valid && ws_allowin) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL retire_unexpected pc=%h wdata=%h", ms_pc, ms_rf_wdata);
         end else begin
            e = sb.pop_front();
            if (ms_pc !== e.pc || ms_rf_wdata !== e.wdata) begin
               failures++;
               $display("FAIL retire pc=%h wdata=%h expected pc=%h wdata=%h",
                        ms_pc, ms_rf_wdata, e.pc, e.wdata);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      es2ms_valid = 0; es_mem_op = 0; es_ld_op = '0; es_addr_lo = '0;
      es_rf_we = 0; es_rf_waddr = '0; es_result = '0; es_pc = '0;
      es_ex_code = '0; es_req_fire = 0; data_sram_data_ok = 0;
      data_sram_rdata = '0; ws_allowin = 1; wb_ex = 0;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [31:0] result,
                        input logic [4:0] waddr, input logic mem,
                        input logic [4:0] ld, input logic [1:0] alo, input logic fire);
      es2ms_valid = 1; es_pc = pc; es_result = result; es_rf_we = 1;
      es_rf_waddr = waddr; es_mem_op = mem; es_ld_op = ld; es_addr_lo = alo;
      es_req_fire = fire;
   endtask

   task automatic test_reset();
      checks++; if (ms2ws_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", ms2ws_valid); end
      checks++; if (ms_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%0d exp=1", ms_allowin); end
      checks++; if (ms_req_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", ms_req_stall); end
      checks++; if (ms_ex !== 1'b0) begin failures++; $display("FAIL reset_ex got=%0d exp=0", ms_ex); end
      checks++; if (ms_fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_fwd got=%0d exp=0", ms_fwd_valid); end
      checks++; if (ms_wr_mask !== 32'h0) begin failures++; $display("FAIL reset_mask got=%h exp=0", ms_wr_mask); end
      checks++; if (ms_outstanding !== '0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", ms_outstanding); end
      checks++; if (ms_rf_wdata !== 32'h0 || ms_pc !== 32'h0) begin failures++; $display("FAIL reset_data wdata=%h pc=%h exp=0", ms_rf_wdata, ms_pc); end
      checks++; if (ms_ex_code !== '0) begin failures++; $display("FAIL reset_excode got=%h exp=0", ms_ex_code); end
   endtask

   task automatic test_nonmem();
      issue(32'h100, 32'h11, 5'd3, 0, 5'b0, 2'd0, 0);
      sb.push_back('{pc: 32'h100, wdata: 32'h11});
      #1;
      checks++; if (ms_allowin !== 1'b1) begin failures++; $display("FAIL nonmem_allowin got=%0d exp=1", ms_allowin); end
      tick();
      issue(32'h104, 32'h22, 5'd4, 0, 5'b0, 2'd0, 0);
      sb.push_back('{pc: 32'h104, wdata: 32'h22});
      #1;
      checks++; if (ms2ws_valid !== 1'b1) begin failures++; $display("FAIL nonmem_valid1 got=%0d exp=1", ms2ws_valid); end
      checks++; if (ms_fwd_valid !== 1'b1 || ms_fwd_wdata !== 32'h11) begin failures++; $display("FAIL nonmem_fwd valid=%0d data=%h exp 1/00000011", ms_fwd_valid, ms_fwd_wdata); end
      checks++; if (ms_wr_mask !== 32'h8) begin failures++; $display("FAIL nonmem_mask got=%h exp=00000008", ms_wr_mask); end
      tick();
      idle();
      #1;
      checks++; if (ms2ws_valid !== 1'b1 || ms_pc !== 32'h104) begin failures++; $display("FAIL nonmem_valid2 valid=%0d pc=%h exp 1/00000104", ms2ws_valid, ms_pc); end
      tick();
      checks++; if (ms2ws_valid !== 1'b0) begin failures++; $display("FAIL nonmem_empty got=%0d exp=0", ms2ws_valid); end
   endtask

   task automatic test_two_loads();
      issue(32'h200, 32'h0, 5'd5, 1, 5'b10000, 2'd3, 1);
      sb.push_back('{pc: 32'h200, wdata: 32'hFFFFFF80});
      tick();
      issue(32'h204, 32'h0, 5'd6, 1, 5'b00010, 2'd2, 1);
      sb.push_back('{pc: 32'h204, wdata: 32'h00001234});
      #1;
      checks++; if (ms_req_stall !== 1'b0 || ms_allowin !== 1'b1) begin failures++; $display("FAIL loads_second_issue stall=%0d allowin=%0d exp 0/1", ms_req_stall, ms_allowin); end
      tick();
      idle();
      #1;
      checks++; if (ms_req_stall !== 1'b1 || ms_outstanding !== 2'd2) begin failures++; $display("FAIL loads_stall stall=%0d out=%0d exp 1/2", ms_req_stall, ms_outstanding); end
      checks++; if (ms_allowin !== 1'b0 || ms2ws_valid !== 1'b0) begin failures++; $display("FAIL loads_full allowin=%0d valid=%0d exp 0/0", ms_allowin, ms2ws_valid); end
      checks++; if (ms_fwd_valid !== 1'b0 || ms_wr_mask !== 32'h60) begin failures++; $display("FAIL loads_hazard fwd=%0d mask=%h exp 0/00000060", ms_fwd_valid, ms_wr_mask); end
      data_sram_data_ok = 1; data_sram_rdata = 32'h80FF7F01;
      #1;
      checks++; if (ms2ws_valid !== 1'b1 || ms_rf_wdata !== 32'hFFFFFF80) begin failures++; $display("FAIL loads_first valid=%0d wdata=%h exp 1/ffffff80", ms2ws_valid, ms_rf_wdata); end
      tick();
      data_sram_rdata = 32'h12345678;
      #1;
      checks++; if (ms_req_stall !== 1'b0) begin failures++; $display("FAIL loads_unstall got=%0d exp=0", ms_req_stall); end
      checks++; if (ms2ws_valid !== 1'b1 || ms_rf_wdata !== 32'h00001234) begin failures++; $display("FAIL loads_second valid=%0d wdata=%h exp 1/00001234", ms2ws_valid, ms_rf_wdata); end
      tick();
      idle();
      #1;
      checks++; if (ms_outstanding !== '0 || ms2ws_valid !== 1'b0) begin failures++; $display("FAIL loads_done out=%0d valid=%0d exp 0/0", ms_outstanding, ms2ws_valid); end
   endtask

   task automatic test_bypass();
      issue(32'h310, 32'h0, 5'd8, 1, 5'b00001, 2'd0, 1);
      sb.push_back('{pc: 32'h310, wdata: 32'hDEADBEEF});
      tick();
      idle();
      #1;
      checks++; if (ms2ws_valid !== 1'b0) begin failures++; $display("FAIL bypass_wait got=%0d exp=0", ms2ws_valid); end
      data_sram_data_ok = 1; data_sram_rdata = 32'hDEADBEEF;
      #1;
      checks++; if (ms2ws_valid !== 1'b1 || ms_rf_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_same_cycle valid=%0d wdata=%h exp 1/deadbeef", ms2ws_valid, ms_rf_wdata); end
      tick();
      idle();
      #1;
      checks++; if (ms2ws_valid !== 1'b0 || ms_outstanding !== '0) begin failures++; $display("FAIL bypass_retired valid=%0d out=%0d exp 0/0", ms2ws_valid, ms_outstanding); end
   endtask

   task automatic test_buffered();
      issue(32'h300, 32'h0, 5'd7, 1, 5'b00100, 2'd0, 1);
      sb.push_back('{pc: 32'h300, wdata: 32'hFFFF8001});
      tick();
      idle();
      ws_allowin = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h00008001;
      #1;
      checks++; if (ms2ws_valid !== 1'b1) begin failures++; $display("FAIL buffered_ready got=%0d exp=1", ms2ws_valid); end
      tick();
      idle();
      ws_allowin = 0;
      #1;
      checks++; if (ms_fwd_valid !== 1'b1 || ms_fwd_waddr !== 5'd7 || ms_fwd_wdata !== 32'hFFFF8001) begin failures++; $display("FAIL buffered_fwd valid=%0d waddr=%0d data=%h exp 1/7/ffff8001", ms_fwd_valid, ms_fwd_waddr, ms_fwd_wdata); end
      checks++; if (ms2ws_valid !== 1'b1 || ms_rf_wdata !== 32'hFFFF8001) begin failures++; $display("FAIL buffered_hold valid=%0d wdata=%h exp 1/ffff8001", ms2ws_valid, ms_rf_wdata); end
      ws_allowin = 1;
      tick();
      checks++; if (ms2ws_valid !== 1'b0) begin failures++; $display("FAIL buffered_retired got=%0d exp=0", ms2ws_valid); end
   endtask

   task automatic test_except();
      issue(32'h320, 32'h55, 5'd9, 1, 5'b00001, 2'd0, 0);
      es_rf_we = 0; es_ex_code = 85'h1; ws_allowin = 0;
      sb.push_back('{pc: 32'h320, wdata: 32'h0});
      tick();
      idle();
      ws_allowin = 0;
      #1;
      checks++; if (ms_ex !== 1'b1 || ms_ex_code !== 85'h1) begin failures++; $display("FAIL except_flag ex=%0d code=%h exp 1/1", ms_ex, ms_ex_code); end
      checks++; if (ms2ws_valid !== 1'b1 || ms_outstanding !== '0) begin failures++; $display("FAIL except_nowait valid=%0d out=%0d exp 1/0", ms2ws_valid, ms_outstanding); end
      ws_allowin = 1;
      tick();
      checks++; if (ms_ex !== 1'b0) begin failures++; $display("FAIL except_cleared got=%0d exp=0", ms_ex); end
   endtask

   task automatic test_full();
      ws_allowin = 0;
      issue(32'h500, 32'hA1, 5'd9, 0, 5'b0, 2'd0, 0);
      sb.push_back('{pc: 32'h500, wdata: 32'hA1});
      tick();
      issue(32'h504, 32'hA2, 5'd10, 0, 5'b0, 2'd0, 0);
      sb.push_back('{pc: 32'h504, wdata: 32'hA2});
      tick();
      issue(32'h508, 32'hA3, 5'd11, 0, 5'b0, 2'd0, 0);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (ms_allowin !== 1'b0 || ms2ws_valid !== 1'b1 || ms_pc !== 32'h500) begin failures++; $display("FAIL full_hold cyc=%0d allowin=%0d valid=%0d pc=%h exp 0/1/00000500", i, ms_allowin, ms2ws_valid, ms_pc); end
         tick();
      end
      ws_allowin = 1;
      sb.push_back('{pc: 32'h508, wdata: 32'hA3});
      #1;
      checks++; if (ms_allowin !== 1'b1) begin failures++; $display("FAIL full_release got=%0d exp=1", ms_allowin); end
      tick();
      idle();
      #1;
      checks++; if (ms_pc !== 32'h504 || ms_allowin !== 1'b1) begin failures++; $display("FAIL full_advance pc=%h allowin=%0d exp 00000504/1", ms_pc, ms_allowin); end
      for (int i = 0; i < 4 && ms2ws_valid; i++) tick();
      checks++; if (ms2ws_valid !== 1'b0) begin failures++; $display("FAIL full_drain got=%0d exp=0", ms2ws_valid); end
   endtask

   task automatic test_flush();
      issue(32'h600, 32'h0, 5'd12, 1, 5'b00001, 2'd0, 1);
      tick();
      issue(32'h604, 32'h0, 5'd13, 1, 5'b00001, 2'd0, 1);
      tick();
      idle();
      #1;
      checks++; if (ms_outstanding !== 2'd2) begin failures++; $display("FAIL flush_pre out=%0d exp=2", ms_outstanding); end
      wb_ex = 1; es_req_fire = 1;
      tick();
      idle();
      #1;
      checks++; if (ms2ws_valid !== 1'b0 || ms_wr_mask !== 32'h0 || ms_allowin !== 1'b1) begin failures++; $display("FAIL flush_empty valid=%0d mask=%h allowin=%0d exp 0/0/1", ms2ws_valid, ms_wr_mask, ms_allowin); end
      checks++; if (ms_outstanding !== 2'd2) begin failures++; $display("FAIL flush_out got=%0d exp=2", ms_outstanding); end
      issue(32'h610, 32'h0, 5'd14, 1, 5'b00001, 2'd0, 0);
      sb.push_back('{pc: 32'h610, wdata: 32'hCAFEF00D});
      data_sram_data_ok = 1; data_sram_rdata = 32'h11111111;
      tick();
      for (int i = 0; i < 2; i++) begin
         idle();
         data_sram_data_ok = 1; data_sram_rdata = 32'h22222222;
         #1;
         checks++; if (ms2ws_valid !== 1'b0) begin failures++; $display("FAIL flush_drop n=%0d valid=%0d exp=0", i, ms2ws_valid); end
         tick();
      end
      idle();
      es_req_fire = 1;
      #1;
      checks++; if (ms_req_stall !== 1'b0 || ms_outstanding !== '0 || ms2ws_valid !== 1'b0) begin failures++; $display("FAIL flush_drained stall=%0d out=%0d valid=%0d exp 0/0/0", ms_req_stall, ms_outstanding, ms2ws_valid); end
      tick();
      idle();
      data_sram_data_ok = 1; data_sram_rdata = 32'hCAFEF00D;
      #1;
      checks++; if (ms2ws_valid !== 1'b1 || ms_rf_wdata !== 32'hCAFEF00D) begin failures++; $display("FAIL flush_fourth valid=%0d wdata=%h exp 1/cafef00d", ms2ws_valid, ms_rf_wdata); end
      tick();
      idle();
      #1;
      checks++; if (ms_outstanding !== '0) begin failures++; $display("FAIL flush_end out=%0d exp=0", ms_outstanding); end
   endtask

   task automatic test_async_reset();
      issue(32'h700, 32'h0, 5'd15, 1, 5'b00001, 2'd0, 1);
      tick();
      issue(32'h704, 32'h0, 5'd16, 1, 5'b00001, 2'd0, 1);
      tick();
      idle();
      #1;
      checks++; if (ms_outstanding !== 2'd2 || ms_wr_mask !== 32'h18000) begin failures++; $display("FAIL areset_pre out=%0d mask=%h exp 2/00018000", ms_outstanding, ms_wr_mask); end
      #1;
      resetn = 0;
      #1;
      checks++; if (ms_outstanding !== '0 || ms_req_stall !== 1'b0) begin failures++; $display("FAIL areset_count out=%0d stall=%0d exp 0/0", ms_outstanding, ms_req_stall); end
      checks++; if (ms_wr_mask !== 32'h0 || ms_pc !== 32'h0 || ms_allowin !== 1'b1) begin failures++; $display("FAIL areset_queue mask=%h pc=%h allowin=%0d exp 0/0/1", ms_wr_mask, ms_pc, ms_allowin); end
      tick();
      resetn = 1;
      tick();
      checks++; if (ms2ws_valid !== 1'b0 || ms_fwd_valid !== 1'b0) begin failures++; $display("FAIL areset_after valid=%0d fwd=%0d exp 0/0", ms2ws_valid, ms_fwd_valid); end
   endtask

   initial begin
      resetn = 0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      resetn = 1;
      tick();
      test_nonmem();
      test_two_loads();
      test_bypass();
      test_buffered();
      test_except();
      test_full();
      test_flush();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
